// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle RISC-V controller: FSM states,
// opcode constants, datapath mux / ALU / immediate encodings, and the
// per-state control-word table used by the controller FSM.
package multicycle_controller_pkg;

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADR   = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      EXE_R     = 4'd6,
      EXE_I     = 4'd7,
      ALU_WB    = 4'd8,
      BRANCH    = 4'd9,
      JAL       = 4'd10,
      JALR      = 4'd11,
      JALR_WB   = 4'd12,
      LUI_WB    = 4'd13
   } state_t;

   // opcodes
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   // ALUControl
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // ImmSrc
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   // datapath muxes
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_REGA  = 2'b10;
   localparam logic [1:0] SRCB_REGB  = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;
   localparam logic [1:0] RES_IMM    = 2'b11;
   localparam logic       ADR_PC     = 1'b0;
   localparam logic       ADR_RESULT = 1'b1;

   // ALUOp handed to the ALU decoder
   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       ir_write;
      logic       reg_write;
      logic       mem_write;
      logic       adr_src;
      logic       branch;     // PCWrite qualified by the live branch condition
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic [1:0] alu_op;
   } ctrl_t;

   // Moore control word for a state; anything not set stays 0 / add.
   function automatic ctrl_t state_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.adr_src    = ADR_PC;
            c.ir_write   = 1'b1;
            c.alu_src_a  = SRCA_PC;
            c.alu_src_b  = SRCB_FOUR;
            c.result_src = RES_ALURES;
            c.pc_write   = 1'b1;
         end
         DECODE: begin
            c.alu_src_a = SRCA_OLDPC;
            c.alu_src_b = SRCB_IMM;
         end
         MEM_ADR: begin
            c.alu_src_a = SRCA_REGA;
            c.alu_src_b = SRCB_IMM;
         end
         MEM_READ: begin
            c.adr_src    = ADR_RESULT;
            c.result_src = RES_ALUOUT;
         end
         MEM_WB: begin
            c.result_src = RES_DATA;
            c.reg_write  = 1'b1;
         end
         MEM_WRITE: begin
            c.adr_src    = ADR_RESULT;
            c.result_src = RES_ALUOUT;
            c.mem_write  = 1'b1;
         end
         EXE_R: begin
            c.alu_src_a = SRCA_REGA;
            c.alu_src_b = SRCB_REGB;
            c.alu_op    = ALUOP_FUNC;
         end
         EXE_I: begin
            c.alu_src_a = SRCA_REGA;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_FUNC;
         end
         ALU_WB: begin
            c.result_src = RES_ALUOUT;
            c.reg_write  = 1'b1;
         end
         BRANCH: begin
            c.alu_src_a  = SRCA_REGA;
            c.alu_src_b  = SRCB_REGB;
            c.alu_op     = ALUOP_SUB;
            c.result_src = RES_ALUOUT;
            c.branch     = 1'b1;
         end
         JAL: begin
            c.result_src = RES_ALUOUT;
            c.pc_write   = 1'b1;
            c.alu_src_a  = SRCA_OLDPC;
            c.alu_src_b  = SRCB_FOUR;
         end
         JALR: begin
            c.alu_src_a  = SRCA_REGA;
            c.alu_src_b  = SRCB_IMM;
            c.result_src = RES_ALURES;
            c.pc_write   = 1'b1;
         end
         JALR_WB: begin
            c.alu_src_a  = SRCA_OLDPC;
            c.alu_src_b  = SRCB_FOUR;
            c.result_src = RES_ALURES;
            c.reg_write  = 1'b1;
         end
         LUI_WB: begin
            c.result_src = RES_IMM;
            c.reg_write  = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   function automatic state_t next_state(input state_t s, input logic [6:0] op);
      state_t n;
      n = FETCH;
      case (s)
         FETCH:  n = DECODE;
         DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: n = MEM_ADR;
               OP_RTYPE:          n = EXE_R;
               OP_ITYPE:          n = EXE_I;
               OP_BRANCH:         n = BRANCH;
               OP_JAL:            n = JAL;
               OP_JALR:           n = JALR;
               OP_LUI:            n = LUI_WB;
               default:           n = FETCH;
            endcase
         end
         MEM_ADR:      n = (op == OP_LOAD) ? MEM_READ : MEM_WRITE;
         MEM_READ:     n = MEM_WB;
         EXE_R, EXE_I: n = ALU_WB;
         JAL:          n = ALU_WB;
         JALR:         n = JALR_WB;
         default:      n = FETCH;
      endcase
      return n;
   endfunction

   function automatic logic [2:0] imm_src(input logic [6:0] op);
      logic [2:0] r;
      case (op)
         OP_LOAD, OP_ITYPE, OP_JALR: r = IMM_I;
         OP_STORE:                   r = IMM_S;
         OP_BRANCH:                  r = IMM_B;
         OP_JAL:                     r = IMM_J;
         OP_LUI:                     r = IMM_U;
         default:                    r = IMM_I;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: turns the FSM's ALUOp plus instruction function bits into
// the 3-bit ALUControl code.
//   i_alu_op   : 00 add, 01 sub, 10 decode from function fields
//   i_func3    : instruction bits [14:12]
//   i_func7_5  : instruction bit 30 (selects sub for R-type)
//   i_op_5     : opcode bit 5 (1 for R-type, 0 for I-type arithmetic)
//   o_alu_ctrl : ALUControl
module alu_decoder
   import multicycle_controller_pkg::*;
(
   input  logic [1:0] i_alu_op,
   input  logic [2:0] i_func3,
   input  logic       i_func7_5,
   input  logic       i_op_5,
   output logic [2:0] o_alu_ctrl
);

   logic [2:0] w_func_ctrl;

   always_comb begin
      w_func_ctrl = ALU_ADD;
      case (i_func3)
         // addi never subtracts, so opcode bit 5 gates func7[5]
         3'b000:  w_func_ctrl = (i_op_5 && i_func7_5) ? ALU_SUB : ALU_ADD;
         3'b111:  w_func_ctrl = ALU_AND;
         3'b110:  w_func_ctrl = ALU_OR;
         3'b100:  w_func_ctrl = ALU_XOR;
         3'b010:  w_func_ctrl = ALU_SLT;
         default: w_func_ctrl = ALU_ADD;
      endcase
   end

   always_comb begin
      o_alu_ctrl = ALU_ADD;
      case (i_alu_op)
         ALUOP_SUB:  o_alu_ctrl = ALU_SUB;
         ALUOP_FUNC: o_alu_ctrl = w_func_ctrl;
         default:    o_alu_ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control unit (Moore FSM).
//   clk, rst           : rising-edge clock, async active-high reset
//   opcode/func3/func7 : instruction fields, stable from DECODE onward
//   zero, negative     : ALU flags of the current cycle (branch decision)
//   PCWrite..AdrSrc    : write enables and address select
//   ALUSrcA/B, ResultSrc, ALUControl, ImmSrc : datapath selects
// The control word for the coming state is registered on each edge, so
// outputs come straight from flops. Two things stay combinational: the
// branch PCWrite (needs this cycle's flags) and the function decode of
// ALUControl / ImmSrc (fields are held stable by the datapath).
module multicycle_controller
   import multicycle_controller_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] func3,
   input  logic [6:0] func7,
   input  logic       zero,
   input  logic       negative,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic       AdrSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ResultSrc,
   output logic [2:0] ALUControl,
   output logic [2:0] ImmSrc
);

   state_t r_state;
   ctrl_t  r_ctrl;
   state_t w_next;
   logic   w_taken;
   logic   w_unused;

   assign w_next = next_state(r_state, opcode);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= FETCH;
         r_ctrl  <= state_ctrl(FETCH);
      end else begin
         r_state <= w_next;
         r_ctrl  <= state_ctrl(w_next);
      end
   end

   always_comb begin
      w_taken = 1'b0;
      case (func3)
         3'b000:  w_taken = zero;
         3'b001:  w_taken = ~zero;
         3'b100:  w_taken = negative;
         3'b101:  w_taken = ~negative;
         default: w_taken = 1'b0;
      endcase
   end

   // Flops reset to the full FETCH word so the first fetch after release
   // is ready immediately; enables are masked while rst is held.
   assign PCWrite   = (r_ctrl.pc_write | (r_ctrl.branch & w_taken)) & ~rst;
   assign IRWrite   = r_ctrl.ir_write  & ~rst;
   assign RegWrite  = r_ctrl.reg_write & ~rst;
   assign MemWrite  = r_ctrl.mem_write & ~rst;
   assign AdrSrc    = r_ctrl.adr_src;
   assign ALUSrcA   = r_ctrl.alu_src_a;
   assign ALUSrcB   = r_ctrl.alu_src_b;
   assign ResultSrc = r_ctrl.result_src;
   assign ImmSrc    = imm_src(opcode);

   alu_decoder u_alu_dec (
      .i_alu_op   (r_ctrl.alu_op),
      .i_func3    (func3),
      .i_func7_5  (func7[5]),
      .i_op_5     (opcode[5]),
      .o_alu_ctrl (ALUControl)
   );

   // only func7[5] matters to this controller
   assign w_unused = ^{func7[6], func7[4:0]};

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;
   import multicycle_controller_pkg::*;

   logic       clk, rst;
   logic [6:0] opcode, func7;
   logic [2:0] func3;
   logic       zero, negative;
   logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc;
   logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
   logic [2:0] ALUControl, ImmSrc;

   multicycle_controller dut (
      .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
      .zero(zero), .negative(negative),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
      .MemWrite(MemWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
      .ImmSrc(ImmSrc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      state_t      st;
      logic [16:0] v;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
   endtask

   // {PCWrite,IRWrite,RegWrite,MemWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl,ImmSrc}
   function automatic logic [16:0] obs();
      return {PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB,
              ResultSrc, ALUControl, ImmSrc};
   endfunction

   // reference control vector straight from the state table
   function automatic logic [16:0] exp_vec(input state_t s, input logic [6:0] op,
                                           input logic [2:0] f3, input logic [6:0] f7,
                                           input logic z, input logic n);
      logic       pcw, irw, rw, mw, adr;
      logic [1:0] sa, sb_, rs;
      logic [2:0] ac, im, fn;
      logic       tk;
      {pcw, irw, rw, mw, adr} = '0;
      sa = 2'b00; sb_ = 2'b00; rs = 2'b00; ac = 3'b000;
      case (op)
         7'b0000011, 7'b0010011, 7'b1100111: im = 3'b000;
         7'b0100011: im = 3'b001;
         7'b1100011: im = 3'b010;
         7'b1101111: im = 3'b011;
         7'b0110111: im = 3'b100;
         default:    im = 3'b000;
      endcase
      case (f3)
         3'b000:  fn = (op == 7'b0110011 && f7[5]) ? 3'b001 : 3'b000;
         3'b111:  fn = 3'b010;
         3'b110:  fn = 3'b011;
         3'b100:  fn = 3'b100;
         3'b010:  fn = 3'b101;
         default: fn = 3'b000;
      endcase
      case (f3)
         3'b000:  tk = z;
         3'b001:  tk = !z;
         3'b100:  tk = n;
         3'b101:  tk = !n;
         default: tk = 1'b0;
      endcase
      case (s)
         FETCH:     begin irw = 1; sb_ = 2'b10; rs = 2'b10; pcw = 1; end
         DECODE:    begin sa = 2'b01; sb_ = 2'b01; end
         MEM_ADR:   begin sa = 2'b10; sb_ = 2'b01; end
         MEM_READ:  begin adr = 1; end
         MEM_WB:    begin rs = 2'b01; rw = 1; end
         MEM_WRITE: begin adr = 1; mw = 1; end
         EXE_R:     begin sa = 2'b10; ac = fn; end
         EXE_I:     begin sa = 2'b10; sb_ = 2'b01; ac = fn; end
         ALU_WB:    begin rw = 1; end
         BRANCH:    begin sa = 2'b10; ac = 3'b001; pcw = tk; end
         JAL:       begin pcw = 1; sa = 2'b01; sb_ = 2'b10; end
         JALR:      begin sa = 2'b10; sb_ = 2'b01; rs = 2'b10; pcw = 1; end
         JALR_WB:   begin sa = 2'b01; sb_ = 2'b10; rs = 2'b10; rw = 1; end
         LUI_WB:    begin rs = 2'b11; rw = 1; end
         default:   ;
      endcase
      return {pcw, irw, rw, mw, adr, sa, sb_, rs, ac, im};
   endfunction

   task automatic push(input state_t s);
      exp_t e;
      e.st = s;
      e.v  = exp_vec(s, opcode, func3, func7, zero, negative);
      sb.push_back(e);
   endtask

   // called #1 after a posedge with the DUT in FETCH; returns likewise
   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic z, input logic n);
      state_t seq[$];
      opcode = op; func3 = f3; func7 = f7; zero = z; negative = n;
      seq.push_back(FETCH);
      seq.push_back(DECODE);
      case (op)
         7'b0000011: begin seq.push_back(MEM_ADR); seq.push_back(MEM_READ); seq.push_back(MEM_WB); end
         7'b0100011: begin seq.push_back(MEM_ADR); seq.push_back(MEM_WRITE); end
         7'b0110011: begin seq.push_back(EXE_R); seq.push_back(ALU_WB); end
         7'b0010011: begin seq.push_back(EXE_I); seq.push_back(ALU_WB); end
         7'b1100011: seq.push_back(BRANCH);
         7'b1101111: begin seq.push_back(JAL); seq.push_back(ALU_WB); end
         7'b1100111: begin seq.push_back(JALR); seq.push_back(JALR_WB); end
         7'b0110111: seq.push_back(LUI_WB);
         default: ;
      endcase
      foreach (seq[i]) push(seq[i]);
      repeat (seq.size()) @(posedge clk);
      #1;
   endtask

   // scoreboard consumer: one expected record per cycle, sampled mid-cycle
   always @(negedge clk) begin
      if (!rst && sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("state", dut.r_state, e.st);
         chk("ctl", obs(), e.v);
      end
   end

   initial begin
      rst = 1'b0; opcode = '0; func3 = '0; func7 = '0; zero = 0; negative = 0;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", dut.r_state, FETCH);
      chk("rst_ctl", obs(), exp_vec(FETCH, opcode, func3, func7, 0, 0) & ~17'h18000);
      rst = 1'b0;

      run_instr(7'b0000011, 3'b010, 7'h00, 0, 0);       // lw
      run_instr(7'b0100011, 3'b010, 7'h00, 0, 0);       // sw
      run_instr(7'b0110011, 3'b000, 7'b0000000, 0, 0);  // add
      run_instr(7'b0110011, 3'b000, 7'b0100000, 0, 0);  // sub
      run_instr(7'b0010011, 3'b000, 7'b0100000, 0, 0);  // addi, func7[5]=1 ignored
      run_instr(7'b0110011, 3'b111, 7'h00, 0, 0);       // and
      run_instr(7'b0110011, 3'b110, 7'h00, 0, 0);       // or
      run_instr(7'b0010011, 3'b100, 7'h00, 0, 0);       // xori
      run_instr(7'b0110011, 3'b010, 7'h00, 0, 0);       // slt
      run_instr(7'b0010011, 3'b001, 7'h00, 0, 0);       // unsupported func3 -> add
      run_instr(7'b1100011, 3'b000, 7'h00, 1, 0);       // beq taken
      run_instr(7'b1100011, 3'b000, 7'h00, 0, 0);       // beq not taken
      run_instr(7'b1100011, 3'b001, 7'h00, 0, 0);       // bne taken
      run_instr(7'b1100011, 3'b001, 7'h00, 1, 0);       // bne not taken
      run_instr(7'b1100011, 3'b100, 7'h00, 0, 1);       // blt taken
      run_instr(7'b1100011, 3'b101, 7'h00, 0, 1);       // bge not taken
      run_instr(7'b1100011, 3'b010, 7'h00, 1, 1);       // undefined func3: never taken
      run_instr(7'b1101111, 3'b000, 7'h00, 0, 0);       // jal
      run_instr(7'b1100111, 3'b000, 7'h00, 0, 0);       // jalr
      run_instr(7'b0110111, 3'b000, 7'h00, 0, 0);       // lui
      run_instr(7'b1111111, 3'b000, 7'h00, 0, 0);       // illegal opcode
      run_instr(7'b0000011, 3'b010, 7'h00, 0, 0);       // lw after illegal

      // sw interrupted by reset while in MEM_WRITE
      opcode = 7'b0100011; func3 = 3'b010; func7 = '0; zero = 0; negative = 0;
      push(FETCH); push(DECODE); push(MEM_ADR); push(MEM_WRITE);
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rstmid_memwrite", {31'd0, MemWrite}, 32'd0);
      chk("rstmid_state", dut.r_state, FETCH);
      chk("rstmid_ctl", obs(), exp_vec(FETCH, opcode, func3, func7, 0, 0) & ~17'h18000);
      @(posedge clk);
      #1 rst = 1'b0;
      run_instr(7'b0110111, 3'b000, 7'h00, 0, 0);       // lui: no stray MemWrite
      run_instr(7'b0100011, 3'b010, 7'h00, 0, 0);       // sw completes normally

      @(negedge clk);
      #1;
      chk("sb_drain", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
